// File: rtl/enc_16x4.sv
// enc_16x4: 16-request encoder with sticky pending capture, round-robin or fixed priority,
// and a valid/ack handshake on the presented 4-bit index.
module enc_16x4 #(
    parameter int ROTATE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    input  logic in5,
    input  logic in6,
    input  logic in7,
    input  logic in8,
    input  logic in9,
    input  logic in10,
    input  logic in11,
    input  logic in12,
    input  logic in13,
    input  logic in14,
    input  logic in15,
    input  logic ack,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic valid,
    output logic more
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0]  r_state;
    logic [15:0] r_p;
    logic [3:0]  r_ptr;
    logic [3:0]  r_idx;
    logic [15:0] w_in;
    logic [15:0] w_clr;
    logic [15:0] w_others;
    logic [3:0]  w_sel;
    logic        w_ack;

    assign w_in = {in15, in14, in13, in12, in11, in10, in9, in8,
                   in7, in6, in5, in4, in3, in2, in1, in0};
    assign w_ack = (r_state == PRESENT) && ack;
    assign w_clr = w_ack ? (16'd1 << r_idx) : 16'd0;

    // Walk downward so the set bit closest to ptr (upward, wrapping) is the last to be assigned.
    always_comb begin
        w_sel = r_ptr;
        for (int i = 15; i >= 0; i--)
            if (r_p[r_ptr + 4'(i)]) w_sel = r_ptr + 4'(i);
    end

    // New captures are OR-ed in after the ack clear, so a request re-raised on the ack edge survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
        end else begin
            r_p <= (r_p & ~w_clr) | w_in;
            if (r_state == IDLE && |r_p) begin
                r_idx   <= w_sel;
                r_state <= PRESENT;
            end else if (w_ack) begin
                r_state <= IDLE;
                r_ptr   <= (ROTATE != 0) ? r_idx + 4'd1 : 4'd0;
            end
        end
    end

    assign {out3, out2, out1, out0} = r_idx;
    assign valid    = (r_state == PRESENT);
    assign w_others = r_p & ~(valid ? (16'd1 << r_idx) : 16'd0);
    assign more     = |w_others;
endmodule

// File: tb/tb_enc_16x4.sv
// tb_enc_16x4: checks a round-robin and a fixed-priority enc_16x4 side by side
// against a per-edge reference model of pending set, pointer and handshake.
module tb_enc_16x4;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] req = '0;
    logic [3:0]  out_r, out_f;
    logic        valid_r, valid_f, more_r, more_f;
    int          checks = 0;
    int          errors = 0;

    bit [15:0] m_p[2];
    int        m_ptr[2];
    bit        m_v[2];
    int        m_idx[2];

    always #5 clk = ~clk;

    enc_16x4 #(.ROTATE(1)) u_rot (
        .clk(clk), .reset(reset),
        .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
        .in4(req[4]), .in5(req[5]), .in6(req[6]), .in7(req[7]),
        .in8(req[8]), .in9(req[9]), .in10(req[10]), .in11(req[11]),
        .in12(req[12]), .in13(req[13]), .in14(req[14]), .in15(req[15]),
        .ack(ack),
        .out0(out_r[0]), .out1(out_r[1]), .out2(out_r[2]), .out3(out_r[3]),
        .valid(valid_r), .more(more_r)
    );

    enc_16x4 #(.ROTATE(0)) u_fix (
        .clk(clk), .reset(reset),
        .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
        .in4(req[4]), .in5(req[5]), .in6(req[6]), .in7(req[7]),
        .in8(req[8]), .in9(req[9]), .in10(req[10]), .in11(req[11]),
        .in12(req[12]), .in13(req[13]), .in14(req[14]), .in15(req[15]),
        .ack(ack),
        .out0(out_f[0]), .out1(out_f[1]), .out2(out_f[2]), .out3(out_f[3]),
        .valid(valid_f), .more(more_f)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_p[k] = '0; m_ptr[k] = 0; m_v[k] = 1'b0; m_idx[k] = 0;
        end
    endtask

    // Model instance 0 rotates, instance 1 always scans from 0.
    task automatic model_edge(input logic [15:0] r, input logic a);
        for (int k = 0; k < 2; k++) begin
            bit [15:0] np;
            bit found;
            np = m_p[k];
            found = 1'b0;
            if (m_v[k]) begin
                if (a) begin
                    np[m_idx[k]] = 1'b0;
                    m_v[k] = 1'b0;
                    if (k == 0) m_ptr[k] = (m_idx[k] + 1) % 16;
                end
            end else if (m_p[k] != 0) begin
                for (int j = 0; j < 16; j++)
                    if (!found && m_p[k][(m_ptr[k] + j) % 16]) begin
                        found = 1'b1;
                        m_idx[k] = (m_ptr[k] + j) % 16;
                    end
                m_v[k] = 1'b1;
            end
            m_p[k] = np | r;
        end
    endtask

    function automatic bit model_more(input int k);
        bit [15:0] t;
        t = m_p[k];
        if (m_v[k]) t[m_idx[k]] = 1'b0;
        return t != 0;
    endfunction

    task automatic cycle(input logic [15:0] r, input logic a);
        @(negedge clk);
        req = r;
        ack = a;
        @(posedge clk);
        model_edge(r, a);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        ack = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req = 16'($urandom);
            ack = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checks++;
            if ({out_r, valid_r, more_r, out_f, valid_f, more_f} !== 12'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: rot out=%0d v=%0b m=%0b fix out=%0d v=%0b m=%0b, required all 0",
                         i, out_r, valid_r, more_r, out_f, valid_f, more_f);
            end
        end
        @(negedge clk);
        req = 16'h0001;
        ack = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        model_edge(16'h0001, 1'b0);
        #1;
        checks++;
        if (valid_r !== 1'b0 || valid_f !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge: v_rot=%0b v_fix=%0b, required 0", valid_r, valid_f);
        end
        cycle(16'h0000, 1'b0);
        checks++;
        if ({valid_r, out_r, valid_f, out_f} !== 10'b1_0000_1_0000) begin
            errors++;
            $display("FAIL reset_second_edge: rot v=%0b out=%0d fix v=%0b out=%0d, required v=1 out=0",
                     valid_r, out_r, valid_f, out_f);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(16'h0000, 1'b0);
            checks++;
            if (valid_r !== 1'b0 || valid_f !== 1'b0 || more_r !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: v_rot=%0b v_fix=%0b m_rot=%0b, required 0",
                         i, valid_r, valid_f, more_r);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        cycle(16'h0020, 1'b0);
        checks++;
        if (valid_r !== 1'b0) begin
            errors++;
            $display("FAIL single_capture: v=%0b, required 0", valid_r);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(16'h0000, 1'b0);
            checks++;
            if ({valid_r, more_r, out_r} !== 6'b1_0_0101 || {valid_f, more_f, out_f} !== 6'b1_0_0101) begin
                errors++;
                $display("FAIL single_present cyc %0d: rot v=%0b m=%0b out=%0d fix v=%0b m=%0b out=%0d, required v=1 m=0 out=5",
                         i, valid_r, more_r, out_r, valid_f, more_f, out_f);
            end
        end
        cycle(16'h0000, 1'b1);
        checks++;
        if ({valid_r, more_r, valid_f, more_f} !== 4'b0000) begin
            errors++;
            $display("FAIL single_ack: rot v=%0b m=%0b fix v=%0b m=%0b, required 0",
                     valid_r, more_r, valid_f, more_f);
        end
        cycle(16'h0000, 1'b0);
        checks++;
        if (valid_r !== 1'b0 || valid_f !== 1'b0) begin
            errors++;
            $display("FAIL single_cleared: v_rot=%0b v_fix=%0b, required 0", valid_r, valid_f);
        end
    endtask

    task automatic test_simultaneous_wrap();
        do_reset();
        cycle(16'h0208, 1'b0);
        cycle(16'h0000, 1'b0);
        checks++;
        if ({valid_r, more_r, out_r} !== 6'b1_1_0011 || {valid_f, more_f, out_f} !== 6'b1_1_0011) begin
            errors++;
            $display("FAIL simul_first: rot v=%0b m=%0b out=%0d fix v=%0b m=%0b out=%0d, required v=1 m=1 out=3",
                     valid_r, more_r, out_r, valid_f, more_f, out_f);
        end
        cycle(16'h0000, 1'b1);
        checks++;
        if ({valid_r, more_r} !== 2'b01) begin
            errors++;
            $display("FAIL simul_gap: v=%0b m=%0b, required v=0 m=1", valid_r, more_r);
        end
        cycle(16'h0000, 1'b0);
        checks++;
        if ({valid_r, more_r, out_r} !== 6'b1_0_1001 || {valid_f, more_f, out_f} !== 6'b1_0_1001) begin
            errors++;
            $display("FAIL simul_second: rot v=%0b m=%0b out=%0d fix v=%0b m=%0b out=%0d, required v=1 m=0 out=9",
                     valid_r, more_r, out_r, valid_f, more_f, out_f);
        end
        cycle(16'h0000, 1'b1);
        cycle(16'h1004, 1'b0);
        checks++;
        if (valid_r !== 1'b0 || out_r !== 4'd9) begin
            errors++;
            $display("FAIL wrap_capture: v=%0b out=%0d, required v=0 out=9 (held)", valid_r, out_r);
        end
        cycle(16'h0000, 1'b0);
        checks++;
        if ({valid_r, more_r, out_r} !== 6'b1_1_1100 || {valid_f, more_f, out_f} !== 6'b1_1_0010) begin
            errors++;
            $display("FAIL wrap_first: rot out=%0d m=%0b fix out=%0d m=%0b, required rot 12 fix 2 m=1",
                     out_r, more_r, out_f, more_f);
        end
        cycle(16'h0000, 1'b1);
        cycle(16'h0000, 1'b0);
        checks++;
        if ({valid_r, more_r, out_r} !== 6'b1_0_0010 || {valid_f, more_f, out_f} !== 6'b1_0_1100) begin
            errors++;
            $display("FAIL wrap_second: rot out=%0d m=%0b fix out=%0d m=%0b, required rot 2 fix 12 m=0",
                     out_r, more_r, out_f, more_f);
        end
        cycle(16'h0000, 1'b1);
    endtask

    task automatic test_collision();
        do_reset();
        cycle(16'h0080, 1'b0);
        cycle(16'h0080, 1'b0);
        checks++;
        if ({valid_r, out_r} !== 5'b1_0111) begin
            errors++;
            $display("FAIL collide_present: v=%0b out=%0d, required v=1 out=7", valid_r, out_r);
        end
        cycle(16'h0080, 1'b1);
        checks++;
        if ({valid_r, more_r, valid_f, more_f} !== 4'b0101) begin
            errors++;
            $display("FAIL collide_ack: rot v=%0b m=%0b fix v=%0b m=%0b, required v=0 m=1",
                     valid_r, more_r, valid_f, more_f);
        end
        cycle(16'h0000, 1'b0);
        checks++;
        if ({valid_r, out_r} !== 5'b1_0111 || {valid_f, out_f} !== 5'b1_0111) begin
            errors++;
            $display("FAIL collide_again: rot v=%0b out=%0d fix v=%0b out=%0d, required v=1 out=7",
                     valid_r, out_r, valid_f, out_f);
        end
        cycle(16'h0000, 1'b1);
        checks++;
        if ({valid_r, more_r} !== 2'b00) begin
            errors++;
            $display("FAIL collide_done: v=%0b m=%0b, required 0", valid_r, more_r);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(16'h0810, 1'b0);
        cycle(16'h0000, 1'b0);
        checks++;
        if (valid_r !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: v=%0b, required 1", valid_r);
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({valid_r, more_r, out_r, valid_f, more_f, out_f} !== 12'd0) begin
            errors++;
            $display("FAIL async_drop: rot v=%0b m=%0b out=%0d fix v=%0b m=%0b out=%0d, required 0",
                     valid_r, more_r, out_r, valid_f, more_f, out_f);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(16'h0000, 1'b0);
            checks++;
            if (valid_r !== 1'b0 || valid_f !== 1'b0) begin
                errors++;
                $display("FAIL async_stale cyc %0d: v_rot=%0b v_fix=%0b, required 0", i, valid_r, valid_f);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            r = 16'($urandom & $urandom & $urandom);
            cycle(r, 1'($urandom_range(0, 1)));
            checks++;
            if ({valid_r, more_r, out_r} !== {m_v[0], model_more(0), 4'(m_idx[0])}) begin
                errors++;
                $display("FAIL random_rot cyc %0d: v=%0b m=%0b out=%0d, required v=%0b m=%0b out=%0d",
                         i, valid_r, more_r, out_r, m_v[0], model_more(0), m_idx[0]);
            end
            checks++;
            if ({valid_f, more_f, out_f} !== {m_v[1], model_more(1), 4'(m_idx[1])}) begin
                errors++;
                $display("FAIL random_fix cyc %0d: v=%0b m=%0b out=%0d, required v=%0b m=%0b out=%0d",
                         i, valid_f, more_f, out_f, m_v[1], model_more(1), m_idx[1]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_simultaneous_wrap();
        test_collision();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/enc_16x4.md
ENC_16X4 -- requirements
Module: enc_16x4

Interface
REQ-001 Parameter ROTATE, default 1: 1 = round-robin priority, 0 = fixed priority with the lowest index winning.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, independent of clk.
REQ-004 in0..in15  input  1 each  request lines; in(k)=1 while sampled at a rising edge means request k is raised.
REQ-005 ack  input  1  consumer accepts the presented index.
REQ-006 out0..out3  output  1 each  encoded index {out3,out2,out1,out0} of the presented request; out0 is the LSB.
REQ-007 valid  output  1  the index on out0..out3 is presented and stable.
REQ-008 more  output  1  at least one pending request other than the presented one exists.

Function
REQ-009 The block SHALL hold a 16-bit pending register P; each rising edge sets P[k] for every in(k)=1 (sticky capture, OR with the existing P).
REQ-010 The block SHALL implement a two-state FSM: IDLE and PRESENT.
REQ-011 In IDLE with P != 0 at an edge, the block SHALL select the winning index, register it on out0..out3, set valid=1 and enter PRESENT; with P == 0 it SHALL stay in IDLE with valid=0.
REQ-012 Selection SHALL scan P upward from the 4-bit pointer ptr, wrapping 15 -> 0, and pick the first set bit.
REQ-013 When ROTATE=0, ptr SHALL stay at 0.
REQ-014 In PRESENT, out0..out3 and valid=1 SHALL be held stable until ack=1 is sampled.
REQ-015 On an edge in PRESENT with ack=1, the block SHALL clear P[idx], set valid=0, return to IDLE and (if ROTATE=1) load ptr = idx+1 mod 16.
REQ-016 If in(idx)=1 on the same edge that clears P[idx], the capture SHALL win: P[idx] stays 1 and the request is re-served later.
REQ-017 ack SHALL be ignored in IDLE.
REQ-018 Latency: a request raised at edge N with the FSM in IDLE and P otherwise 0 SHALL show valid=1 after edge N+1.
REQ-019 Minimum spacing between grants SHALL be 2 cycles: one PRESENT cycle plus one IDLE cycle.
REQ-020 more SHALL be combinational from registered state: (P with the bit of the presented index masked when valid=1) != 0.
REQ-021 out0..out3 SHALL keep their last value while in IDLE; consumers qualify them with valid.

Reset
REQ-022 While reset=0 the block SHALL force P=0, ptr=0, FSM=IDLE, out0..out3=0, valid=0; more is then 0, since it is derived from P.
REQ-023 Reset asserted mid-PRESENT SHALL drop valid to 0 immediately, without waiting for clk, and discard all pending requests.
REQ-024 After reset deasserts, the first rising edge SHALL only capture inputs; the earliest valid=1 is after the second edge.

Verification
REQ-025 Reset check: reset=0 with random inputs -> out=0000, valid=0, more=0 throughout; after release with all inputs 0 -> valid stays 0.
REQ-026 Single request: in5 pulsed high for one edge -> after the next edge valid=1, out=0101, more=0; held for 3 cycles with ack=0; ack=1 for one edge -> valid=0 and P=0.
REQ-027 Simultaneous requests: in3 and in9 together at ptr=0 -> out=0011 with more=1; ack -> out=1001 with more=0; ack -> idle, ptr=10.
REQ-028 Wrap-around: ptr=10, pending {2,12} -> grants 12 (1100) then 2 (0010); with ROTATE=0 and the same pending set -> 2 then 12.
REQ-029 Collision: in7 held high continuously while index 7 is acked -> P[7] stays set, and 7 is presented again after the IDLE cycle.
REQ-030 Async reset mid-PRESENT: reset=0 between clock edges -> valid=0 immediately; after release with no inputs, no stale index is ever presented.
